// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: constants shared between the fetch stage and the later
// decode/execute stages.
//   InstAddrBus / InstBus : default instruction-address and instruction widths
//   ZeroWord              : all-zero address word
//   RstEnable             : active level of the synchronous reset
//   WriteEnable           : active level of write strobes
//   PcStepBytes           : PC increment per sequential instruction
//   NopInst               : instruction encoding injected as a bubble
package if_fetch_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 64;

   localparam logic [InstAddrBus-1:0] ZeroWord    = '0;
   localparam logic                   RstEnable   = 1'b1;
   localparam logic                   WriteEnable = 1'b1;

   localparam int                     PcStepBytes = 8;
   localparam logic [InstBus-1:0]     NopInst     = '0;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: generic synchronous FIFO, first-word-fall-through on dout.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write din when push (accepted if not full, or full with pop)
//   pop       : drop head entry (ignored when empty)
//   clear     : empty the FIFO; wins over push/pop
//   dout      : current head entry (undefined content when empty)
//   count     : occupancy 0..DEPTH
//   full/empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo
   import if_fetch_pkg::*;
#(
   parameter  int WIDTH = 96,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when the head leaves in the same cycle:
   // the freed slot is the one the write pointer already addresses.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (rst != RstEnable && !clear && do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage and IF/ID boundary register.
//   clk, rst          : clock, synchronous active-high reset
//   stall_i           : hold the IF/ID outputs
//   flush_i, new_pc_i : redirect; drop all buffered and in-flight fetches
//   imem_req_o/addr_o : fetch request and address (address = fetch PC)
//   imem_gnt_i        : request accepted when req & gnt
//   imem_rvalid_i/rdata_i : in-order responses, one per granted request
//   pc_o, inst_o, valid_o : {pc, inst} to decode; inst_o = NOP when !valid_o
// Optional feature macro IF_BYPASS_EN: a kept response arriving while the
// FIFO is empty and decode is not stalled goes straight into the output
// register, saving one cycle of fetch latency.
// Issue is credit-limited: buffered + outstanding never exceeds DEPTH, so
// every response always has a FIFO slot.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int                ADDR_W   = InstAddrBus,
   parameter int                INST_W   = InstBus,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = PcStepBytes,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] new_pc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int ENT_W = ADDR_W + INST_W;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  discard_q, discard_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              valid_q, valid_d;

   logic              fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
   logic [ENT_W-1:0]  fifo_dout;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              issue, rsp, rsp_drop, rsp_take, bypass;

   if_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clear (fifo_clear),
      .din   ({resp_pc_q, imem_rdata_i}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
   assign imem_req_o  = (rst != RstEnable) & ~flush_i
                        & (credit_used < (CNT_W+1)'(DEPTH));
   assign imem_addr_o = fetch_pc_q;
   assign issue       = imem_req_o & imem_gnt_i;

   // With nothing outstanding an rvalid cannot belong to us (e.g. a
   // response to a request made before reset), so it is ignored outright.
   assign rsp      = imem_rvalid_i & (outst_q != '0);
   assign rsp_drop = rsp & (flush_i | (discard_q != '0));
   assign rsp_take = rsp & ~rsp_drop;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q + CNT_W'(issue) - CNT_W'(rsp);
      discard_d  = discard_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      bypass     = 1'b0;

      if (issue)    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_take) resp_pc_d  = resp_pc_q + ADDR_W'(PC_STEP);
      if (rsp && discard_q != '0) discard_d = discard_q - CNT_W'(1);

      if (flush_i) begin
         // Everything still in flight after this cycle belongs to the old
         // stream; issue is blocked this cycle so outst_d is exactly that.
         fetch_pc_d = new_pc_i;
         resp_pc_d  = new_pc_i;
         discard_d  = outst_q - CNT_W'(rsp);
         fifo_clear = 1'b1;
         valid_d    = 1'b0;
         inst_d     = NopInst;
      end else if (!stall_i) begin
         if (!fifo_empty) begin
            fifo_pop       = 1'b1;
            {pc_d, inst_d} = fifo_dout;
            valid_d        = 1'b1;
         end
`ifdef IF_BYPASS_EN
         else if (rsp_take) begin
            bypass  = 1'b1;
            pc_d    = resp_pc_q;
            inst_d  = imem_rdata_i;
            valid_d = 1'b1;
         end
`endif
         else begin
            valid_d = 1'b0;
            inst_d  = NopInst;
         end
      end

      fifo_push = rsp_take & ~bypass;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         pc_q       <= '0;
         inst_q     <= NopInst;
         valid_q    <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign inst_o  = inst_q;
   assign valid_o = valid_q;

   // Credit accounting must make an overflowing push impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop && !fifo_clear));

endmodule
